// File: rtl/atcdmac300_chsched.sv
// rtl/atcdmac300_chsched.sv - DMA channel scheduler between arbiter and transfer engine
module atcdmac300_chsched #(
   parameter int BURST_LIMIT = 16,
   parameter int CNT_W       = 5,
   parameter bit YIELD_EN    = 1'b1
) (
   input  logic       hclk,
   input  logic       hresetn,
   input  logic [7:0] ch_request,
   input  logic [7:0] ch_abort,
   input  logic [2:0] granted_channel,
   output logic [2:0] current_channel,
   output logic       eng_start,
   output logic [2:0] eng_channel,
   input  logic       eng_ack,
   input  logic       eng_beat,
   input  logic       eng_done,
   output logic       eng_yield,
   output logic       busy,
   output logic [7:0] ch_serviced
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARB    = 3'd1,
      ST_START  = 3'd2,
      ST_XFER   = 3'd3,
      ST_UPDATE = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BURST_LIMIT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state_q, state_d;
   logic [2:0]       sel_ch_q, sel_ch_d;
   logic [2:0]       cur_ch_q, cur_ch_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic             yield_q, yield_d;

   // State and datapath registers; reset returns to IDLE even mid-transfer
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q    <= ST_IDLE;
         sel_ch_q   <= 3'd0;
         cur_ch_q   <= 3'd0;
         beat_cnt_q <= '0;
         yield_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_ch_q   <= sel_ch_d;
         cur_ch_q   <= cur_ch_d;
         beat_cnt_q <= beat_cnt_d;
         yield_q    <= yield_d;
      end
   end

   // Next-state logic: grant sampling, engine handshake, beat counting and yield request
   always_comb begin
      state_d    = state_q;
      sel_ch_d   = sel_ch_q;
      cur_ch_d   = cur_ch_q;
      beat_cnt_d = beat_cnt_q;
      yield_d    = yield_q;
      case (state_q)
         ST_IDLE: begin
            if (|ch_request) state_d = ST_ARB;
         end
         ST_ARB: begin
            sel_ch_d = granted_channel;
            state_d  = ch_request[granted_channel] ? ST_START : ST_IDLE;
         end
         ST_START: begin
            // An ack wins over a same-cycle abort: once the engine has accepted,
            // the grant is closed through eng_done and the abort becomes a yield.
            if (eng_ack) begin
               state_d    = ST_XFER;
               beat_cnt_d = '0;
            end else if (ch_abort[sel_ch_q]) begin
               state_d = ST_UPDATE;
            end
         end
         ST_XFER: begin
            // eng_done has priority so a yield is never raised on the closing cycle
            if (eng_done) begin
               state_d = ST_UPDATE;
               yield_d = 1'b0;
            end else begin
               if (eng_beat && (beat_cnt_q != CNT_MAX)) beat_cnt_d = beat_cnt_q + CNT_ONE;
               if ((YIELD_EN && eng_beat && (beat_cnt_q == BEAT_LAST)) || ch_abort[sel_ch_q])
                  yield_d = 1'b1;
            end
         end
         ST_UPDATE: begin
            cur_ch_d = sel_ch_q;
            yield_d  = 1'b0;
            state_d  = (|ch_request) ? ST_ARB : ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign current_channel = cur_ch_q;
   assign eng_start       = (state_q == ST_START);
   assign eng_channel     = sel_ch_q;
   assign eng_yield       = yield_q;
   assign busy            = (state_q != ST_IDLE);
   assign ch_serviced     = (state_q == ST_UPDATE) ? (8'h01 << sel_ch_q) : 8'h00;

endmodule

// File: tb/tb_atcdmac300_chsched.sv
// tb/tb_atcdmac300_chsched.sv - scoreboard bench for atcdmac300_chsched
module tb_atcdmac300_chsched;

   logic       hclk = 1'b0;
   logic       hresetn;
   logic [7:0] ch_request, ch_abort;
   logic [2:0] granted_channel, current_channel, eng_channel;
   logic       eng_start, eng_ack, eng_beat, eng_done, eng_yield, busy;
   logic [7:0] ch_serviced;

   logic [7:0] req2, abort2;
   logic [2:0] gnt2, cur2, chan2;
   logic       start2, ack2, beat2, done2, yield2, busy2;
   logic [7:0] svc2;

   int n_checks = 0;
   int n_errs   = 0;
   logic [2:0] exp_grant_q[$];
   logic [2:0] exp_svc_q[$];
   logic       start_prev = 1'b0;

   always #5 hclk = ~hclk;

   // Round-robin arbiter model: search starts after cur and wraps back to cur
   function automatic logic [2:0] rr_arb(input logic [7:0] req, input logic [2:0] cur);
      logic [2:0] c;
      logic       found;
      rr_arb = cur;
      found  = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         c = cur + 3'(i);
         if (!found && req[c]) begin
            rr_arb = c;
            found  = 1'b1;
         end
      end
   endfunction

   assign granted_channel = rr_arb(ch_request, current_channel);
   assign gnt2            = rr_arb(req2, cur2);

   atcdmac300_chsched #(.BURST_LIMIT(4), .CNT_W(5), .YIELD_EN(1'b1)) dut (
      .hclk(hclk), .hresetn(hresetn), .ch_request(ch_request), .ch_abort(ch_abort),
      .granted_channel(granted_channel), .current_channel(current_channel),
      .eng_start(eng_start), .eng_channel(eng_channel), .eng_ack(eng_ack),
      .eng_beat(eng_beat), .eng_done(eng_done), .eng_yield(eng_yield),
      .busy(busy), .ch_serviced(ch_serviced)
   );

   atcdmac300_chsched #(.BURST_LIMIT(16), .CNT_W(5), .YIELD_EN(1'b0)) dut_ny (
      .hclk(hclk), .hresetn(hresetn), .ch_request(req2), .ch_abort(abort2),
      .granted_channel(gnt2), .current_channel(cur2),
      .eng_start(start2), .eng_channel(chan2), .eng_ack(ack2),
      .eng_beat(beat2), .eng_done(done2), .eng_yield(yield2),
      .busy(busy2), .ch_serviced(svc2)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Scoreboard monitor: grants on eng_start rising, releases on ch_serviced pulses
   always @(negedge hclk) begin
      if (eng_start && !start_prev) begin
         if (exp_grant_q.size() == 0) check_val("grant_unexpected", 1, 0);
         else check_val("grant_ch", {29'd0, eng_channel}, {29'd0, exp_grant_q.pop_front()});
      end
      start_prev <= eng_start;
      if (ch_serviced != 8'h00) begin
         check_val("update_yield_low", {31'd0, eng_yield}, 0);
         if (exp_svc_q.size() == 0) check_val("serviced_unexpected", {24'd0, ch_serviced}, 0);
         else check_val("serviced", {24'd0, ch_serviced}, 32'h1 << exp_svc_q.pop_front());
      end
   end

   task automatic wait_start();
      int k = 0;
      while (!eng_start && k < 30) begin
         @(negedge hclk);
         k++;
      end
      check_val("start_seen", {31'd0, eng_start}, 1);
   endtask

   // Engine model: ack, beat every cycle until yield or budget, then done
   task automatic engine_run(input int budget, output int nbeats, output bit yseen);
      wait_start();
      eng_ack = 1'b1;
      @(negedge hclk);
      eng_ack = 1'b0;
      nbeats  = 0;
      while (nbeats < budget && !eng_yield) begin
         eng_beat = 1'b1;
         nbeats++;
         @(negedge hclk);
      end
      eng_beat = 1'b0;
      yseen    = eng_yield;
      eng_done = 1'b1;
      @(negedge hclk);
      eng_done = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int  nb, k;
      bit  ys;
      logic ny_y;
      hresetn = 1'b0; ch_request = 8'h00; ch_abort = 8'h00;
      eng_ack = 1'b0; eng_beat = 1'b0; eng_done = 1'b0;
      req2 = 8'h00; abort2 = 8'h00; ack2 = 1'b0; beat2 = 1'b0; done2 = 1'b0;
      repeat (3) @(negedge hclk);
      check_val("rst_start", {31'd0, eng_start}, 0);
      check_val("rst_busy", {31'd0, busy}, 0);
      check_val("rst_cur", {29'd0, current_channel}, 0);
      check_val("rst_chan", {29'd0, eng_channel}, 0);
      check_val("rst_yield", {31'd0, eng_yield}, 0);
      check_val("rst_svc", {24'd0, ch_serviced}, 0);
      hresetn = 1'b1;
      @(negedge hclk);

      // Single request on channel 0: eng_start two cycles later
      exp_grant_q.push_back(3'd0); exp_svc_q.push_back(3'd0);
      ch_request = 8'h01;
      @(negedge hclk);
      check_val("lat_c1_start", {31'd0, eng_start}, 0);
      @(negedge hclk);
      check_val("lat_c2_start", {31'd0, eng_start}, 1);
      eng_ack = 1'b1;
      @(negedge hclk);
      eng_ack = 1'b0;
      check_val("start_drop", {31'd0, eng_start}, 0);
      eng_done = 1'b1; ch_request = 8'h00;
      @(negedge hclk);
      eng_done = 1'b0;
      @(negedge hclk);
      check_val("t1_cur", {29'd0, current_channel}, 0);
      check_val("t1_idle", {31'd0, busy}, 0);

      // Engine strobes while idle are ignored
      eng_ack = 1'b1; eng_beat = 1'b1; eng_done = 1'b1;
      @(negedge hclk);
      eng_ack = 1'b0; eng_beat = 1'b0; eng_done = 1'b0;
      @(negedge hclk);
      check_val("idle_ignore_busy", {31'd0, busy}, 0);

      // Two requesters time-slice: 7,0,7,0 with yield after the 4th beat
      ch_request = 8'h81;
      for (int g = 0; g < 4; g++) begin
         exp_grant_q.push_back((g % 2 == 0) ? 3'd7 : 3'd0);
         exp_svc_q.push_back((g % 2 == 0) ? 3'd7 : 3'd0);
      end
      for (int g = 0; g < 4; g++) begin
         engine_run(50, nb, ys);
         check_val("ts_beats", nb, 4);
         check_val("ts_yield", {31'd0, ys}, 1);
      end
      ch_request = 8'h00;
      @(negedge hclk);
      check_val("ts_cur", {29'd0, current_channel}, 0);

      // No time-slicing: 40 beats on ch3, counter saturates, no yield
      req2 = 8'h08;
      k = 0;
      while (!start2 && k < 20) begin
         @(negedge hclk);
         k++;
      end
      check_val("ny_start", {31'd0, start2}, 1);
      check_val("ny_chan", {29'd0, chan2}, 3);
      ack2 = 1'b1;
      @(negedge hclk);
      ack2 = 1'b0;
      ny_y = 1'b0;
      repeat (40) begin
         beat2 = 1'b1;
         @(negedge hclk);
         ny_y = ny_y | yield2;
      end
      beat2 = 1'b0;
      check_val("ny_no_yield", {31'd0, ny_y}, 0);
      check_val("ny_sat_cnt", {27'd0, dut_ny.beat_cnt_q}, 31);
      done2 = 1'b1; req2 = 8'h00;
      @(negedge hclk);
      done2 = 1'b0;
      check_val("ny_serviced", {24'd0, svc2}, 32'h08);
      @(negedge hclk);
      check_val("ny_cur", {29'd0, cur2}, 3);
      check_val("ny_idle", {31'd0, busy2}, 0);

      // Abort on ch5 before ack: straight to UPDATE, no transfer
      exp_grant_q.push_back(3'd5); exp_svc_q.push_back(3'd5);
      ch_request = 8'h20;
      wait_start();
      ch_abort = 8'h20;
      @(negedge hclk);
      ch_abort = 8'h00; ch_request = 8'h00;
      check_val("abort_start_low", {31'd0, eng_start}, 0);
      check_val("abort_no_yield", {31'd0, eng_yield}, 0);
      @(negedge hclk);
      check_val("abort_cur", {29'd0, current_channel}, 5);

      // eng_done together with the 4th beat: done wins, no yield
      exp_grant_q.push_back(3'd3); exp_svc_q.push_back(3'd3);
      ch_request = 8'h08;
      wait_start();
      eng_ack = 1'b1;
      @(negedge hclk);
      eng_ack = 1'b0;
      repeat (3) begin
         eng_beat = 1'b1;
         @(negedge hclk);
      end
      eng_beat = 1'b1; eng_done = 1'b1; ch_request = 8'h00;
      @(negedge hclk);
      eng_beat = 1'b0; eng_done = 1'b0;
      @(negedge hclk);
      check_val("donebeat_yield", {31'd0, eng_yield}, 0);
      check_val("donebeat_cur", {29'd0, current_channel}, 3);

      // Reset during a transfer on ch6, then search restarts from channel 1
      exp_grant_q.push_back(3'd6);
      ch_request = 8'h40;
      wait_start();
      eng_ack = 1'b1;
      @(negedge hclk);
      eng_ack = 1'b0;
      repeat (2) begin
         eng_beat = 1'b1;
         @(negedge hclk);
      end
      eng_beat = 1'b0; ch_request = 8'h00; hresetn = 1'b0;
      #1;
      check_val("mrst_start", {31'd0, eng_start}, 0);
      check_val("mrst_busy", {31'd0, busy}, 0);
      check_val("mrst_cur", {29'd0, current_channel}, 0);
      check_val("mrst_chan", {29'd0, eng_channel}, 0);
      @(negedge hclk);
      hresetn = 1'b1;
      exp_grant_q.push_back(3'd1); exp_svc_q.push_back(3'd1);
      ch_request = 8'h03;
      engine_run(2, nb, ys);
      check_val("post_rst_beats", nb, 2);
      check_val("post_rst_no_yield", {31'd0, ys}, 0);
      ch_request = 8'h00;
      @(negedge hclk);
      check_val("post_rst_cur", {29'd0, current_channel}, 1);

      @(negedge hclk);
      check_val("grant_q_empty", exp_grant_q.size(), 0);
      check_val("svc_q_empty", exp_svc_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
